// File: rtl/seg_7_display_ctrl.sv
// Seven-segment display controller: serial double-dabble binary-to-BCD
// conversion, leading-zero blanking, minus-sign placement, overflow
// flagging, plus a parallel segment bus and a multiplexed scan output.
module seg_7_display_ctrl #(
  parameter int DIGITS   = 6,
  parameter int WIDTH    = 20,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic [WIDTH-1:0]      i_number,
  input  logic                  i_minus_sign,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_seg,
  output logic [DIGITS-1:0]     o_sel,
  output logic [6:0]            o_seg_scan
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int SCW  = $clog2(SCAN_DIV);
  localparam int IDXW = $clog2(DIGITS);

  localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FMT  = 2'd2;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} pattern for a single BCD digit.
  function automatic logic [6:0] digitToSeg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [1:0]          r_state;
  logic [WIDTH-1:0]    r_bin;
  logic [BCDW-1:0]     r_bcd;
  logic                r_minus;
  logic                r_ovfSticky;
  logic [CNTW-1:0]     r_bitCount;
  logic [7*DIGITS-1:0] r_seg;
  logic                r_overflow;
  logic                r_done;

  logic [SCW-1:0]      r_scanCount;
  logic [IDXW-1:0]     r_scanIdx;
  logic [DIGITS-1:0]   r_sel;
  logic [6:0]          r_segScan;

  logic [BCDW-1:0]     w_bcdAdj;
  logic [7*DIGITS-1:0] w_segFmt;
  logic                w_ovfFmt;
  logic                w_nonZero;
  int                  w_msd;
  logic                w_scanWrap;
  logic [IDXW-1:0]     w_scanIdxNext;

  // Add-3 correction of every BCD nibble that would reach 10 or more after the shift.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Build the display image from the finished BCD value: blanking, sign, overflow.
  always_comb begin
    w_msd     = 0;
    w_nonZero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        w_msd     = i;
        w_nonZero = 1'b1;
      end
    end
    w_ovfFmt = r_ovfSticky || (r_minus && w_nonZero && (w_msd == DIGITS - 1));
    w_segFmt = {DIGITS{SEG_BLANK}};
    if (w_ovfFmt) begin
      w_segFmt = {DIGITS{SEG_MINUS}};
    end else if (!w_nonZero) begin
      w_segFmt[6:0] = digitToSeg(4'd0);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i <= w_msd) begin
          w_segFmt[7*i +: 7] = digitToSeg(r_bcd[4*i +: 4]);
        end else if (r_minus && (i == w_msd + 1)) begin
          w_segFmt[7*i +: 7] = SEG_MINUS;
        end
      end
    end
  end

  // Conversion state machine: capture on load, one shift per clock, then publish.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_minus     <= 1'b0;
      r_ovfSticky <= 1'b0;
      r_bitCount  <= '0;
      r_seg       <= {DIGITS{SEG_BLANK}};
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_bin       <= i_number;
            r_minus     <= i_minus_sign;
            r_bcd       <= '0;
            r_ovfSticky <= 1'b0;
            r_bitCount  <= CNTW'(WIDTH);
            r_state     <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd <= {w_bcdAdj[BCDW-2:0], r_bin[WIDTH-1]};
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          if (w_bcdAdj[BCDW-1]) begin
            r_ovfSticky <= 1'b1;
          end
          r_bitCount <= r_bitCount - CNTW'(1);
          if (r_bitCount == CNTW'(1)) begin
            r_state <= S_FMT;
          end
        end
        S_FMT: begin
          r_seg      <= w_segFmt;
          r_overflow <= w_ovfFmt;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Next scan position; computed ahead so sel/seg_scan move on the same edge as the index.
  always_comb begin
    w_scanWrap    = (r_scanCount == SCAN_LAST);
    w_scanIdxNext = r_scanIdx;
    if (w_scanWrap) begin
      w_scanIdxNext = (r_scanIdx == IDX_LAST) ? '0 : r_scanIdx + IDXW'(1);
    end
  end

  // Free-running digit scanner, independent of the conversion engine.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_scanCount <= '0;
      r_scanIdx   <= '0;
      r_sel       <= ~DIGITS'(1);
      r_segScan   <= SEG_BLANK;
    end else begin
      r_scanCount <= w_scanWrap ? '0 : r_scanCount + SCW'(1);
      r_scanIdx   <= w_scanIdxNext;
      r_sel       <= ~(DIGITS'(1) << w_scanIdxNext);
      r_segScan   <= r_seg[7*int'(w_scanIdxNext) +: 7];
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_seg      = r_seg;
  assign o_sel      = r_sel;
  assign o_seg_scan = r_segScan;

endmodule

// File: tb/tb_seg_7_display_ctrl.sv
// Self-checking bench for seg_7_display_ctrl: directed cases plus randomized
// values compared against a decimal-arithmetic model of the display.
module tb_seg_7_display_ctrl;

  localparam int DIGITS   = 6;
  localparam int WIDTH    = 20;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] P_MINUS = 7'b0111111;
  localparam logic [6:0] P_BLANK = 7'b1111111;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  number = '0;
  logic              minusSign = 1'b0;
  logic              load = 1'b0;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [7*DIGITS-1:0] seg;
  logic [DIGITS-1:0] sel;
  logic [6:0]        segScan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_7_display_ctrl #(
    .DIGITS   (DIGITS),
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst),
    .i_number     (number),
    .i_minus_sign (minusSign),
    .i_load       (load),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_seg        (seg),
    .o_sel        (sel),
    .o_seg_scan   (segScan)
  );

  // Segment pattern of a decimal numeral.
  function automatic logic [6:0] numeral(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return P_BLANK;
    endcase
  endfunction

  // Expected {overflow, seg} from the display rules using decimal arithmetic.
  function automatic logic [7*DIGITS:0] modelDisplay(input longint n, input bit neg);
    logic [7*DIGITS-1:0] s;
    int nd;
    longint v;
    s = {DIGITS{P_BLANK}};
    if (n >= 1000000) return {1'b1, {DIGITS{P_MINUS}}};
    if (n == 0) begin
      s[6:0] = numeral(0);
      return {1'b0, s};
    end
    nd = 0;
    v  = n;
    while (v > 0) begin
      s[7*nd +: 7] = numeral(int'(v % 10));
      v = v / 10;
      nd++;
    end
    if (neg) begin
      if (nd == DIGITS) return {1'b1, {DIGITS{P_MINUS}}};
      s[7*nd +: 7] = P_MINUS;
    end
    return {1'b0, s};
  endfunction

  // Issue one load and observe 40 cycles: busy length, done pulses, done position.
  task automatic runConversion(input logic [WIDTH-1:0] n, input logic neg,
                               output int busyCycles, output int doneCount, output int firstDone);
    @(negedge clk);
    number    = n;
    minusSign = neg;
    load      = 1'b1;
    @(negedge clk);
    load       = 1'b0;
    busyCycles = 0;
    doneCount  = 0;
    firstDone  = -1;
    for (int c = 1; c <= 40; c++) begin
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (seg !== {DIGITS{P_BLANK}}) begin errors++; $display("[TB] FAIL reset_seg: got %b expected all blank", seg); end
    checks++; if (sel !== 6'b111110) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 111110", sel); end
    checks++; if (segScan !== P_BLANK) begin errors++; $display("[TB] FAIL reset_seg_scan: got %b expected %b", segScan, P_BLANK); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int bc, dc, fd;
    runConversion(20'd0, 1'b1, bc, dc, fd);
    checks++; if (seg !== {{5{P_BLANK}}, 7'b1000000}) begin errors++; $display("[TB] FAIL zero_seg: got %b expected 0 with blanks", seg); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL zero_overflow: got %b expected 0", overflow); end
    checks++; if (dc != 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d expected 1", dc); end
    checks++; if (fd != 22) begin errors++; $display("[TB] FAIL zero_done_latency: got %0d expected 22", fd); end
    checks++; if (bc != 21) begin errors++; $display("[TB] FAIL zero_busy_len: got %0d expected 21", bc); end
  endtask

  task automatic test_minus_interior();
    int bc, dc, fd;
    logic [7*DIGITS-1:0] expSeg;
    expSeg = {P_BLANK, P_MINUS, numeral(1), numeral(2), numeral(0), numeral(3)};
    runConversion(20'd1203, 1'b1, bc, dc, fd);
    checks++; if (seg !== expSeg) begin errors++; $display("[TB] FAIL neg1203_seg: got %b expected %b", seg, expSeg); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL neg1203_overflow: got %b expected 0", overflow); end
    checks++; if (bc != 21) begin errors++; $display("[TB] FAIL neg1203_busy_len: got %0d expected 21", bc); end
    checks++; if (dc != 1) begin errors++; $display("[TB] FAIL neg1203_done_count: got %0d expected 1", dc); end
  endtask

  task automatic test_overflow();
    int bc, dc, fd;
    runConversion(20'd1000000, 1'b0, bc, dc, fd);
    checks++; if (seg !== {DIGITS{P_MINUS}}) begin errors++; $display("[TB] FAIL ovf_big_seg: got %b expected all minus", seg); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_big_flag: got %b expected 1", overflow); end
    runConversion(20'd100000, 1'b1, bc, dc, fd);
    checks++; if (seg !== {DIGITS{P_MINUS}}) begin errors++; $display("[TB] FAIL ovf_sign_seg: got %b expected all minus", seg); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sign_flag: got %b expected 1", overflow); end
    runConversion(20'd999999, 1'b0, bc, dc, fd);
    checks++; if (seg !== {DIGITS{numeral(9)}}) begin errors++; $display("[TB] FAIL max_seg: got %b expected all nines", seg); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL max_flag: got %b expected 0", overflow); end
  endtask

  task automatic test_random();
    int bc, dc, fd;
    logic [WIDTH-1:0] n;
    logic neg;
    logic [7*DIGITS:0] exp;
    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 3))
        0:       n = WIDTH'($urandom);
        1:       n = WIDTH'($urandom_range(0, 99));
        2:       n = WIDTH'($urandom_range(0, 99999));
        default: n = WIDTH'($urandom_range(990000, 1048575));
      endcase
      neg = 1'($urandom);
      exp = modelDisplay(longint'(n), neg);
      runConversion(n, neg, bc, dc, fd);
      checks++; if (seg !== exp[7*DIGITS-1:0]) begin errors++; $display("[TB] FAIL rand_seg n=%0d neg=%b: got %b expected %b", n, neg, seg, exp[7*DIGITS-1:0]); end
      checks++; if (overflow !== exp[7*DIGITS]) begin errors++; $display("[TB] FAIL rand_overflow n=%0d neg=%b: got %b expected %b", n, neg, overflow, exp[7*DIGITS]); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL rand_done_count n=%0d: got %0d expected 1", n, dc); end
    end
  endtask

  task automatic test_load_ignored();
    int dc;
    logic [7*DIGITS:0] exp;
    exp = modelDisplay(42, 1'b0);
    @(negedge clk);
    number = 20'd42; minusSign = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    number = 20'd77; minusSign = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) dc++;
      @(negedge clk);
    end
    checks++; if (seg !== exp[7*DIGITS-1:0]) begin errors++; $display("[TB] FAIL ignore_load_seg: got %b expected %b", seg, exp[7*DIGITS-1:0]); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ignore_load_overflow: got %b expected 0", overflow); end
    checks++; if (dc != 1) begin errors++; $display("[TB] FAIL ignore_load_done_count: got %0d expected 1", dc); end
  endtask

  task automatic test_reset_mid_conv();
    int bc, dc, fd;
    runConversion(20'd1000000, 1'b0, bc, dc, fd);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_overflow: got %b expected 1", overflow); end
    @(negedge clk);
    number = 20'd555; minusSign = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (seg !== {DIGITS{P_BLANK}}) begin errors++; $display("[TB] FAIL midrst_seg: got %b expected all blank", seg); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overflow: got %b expected 0", overflow); end
    checks++; if (sel !== 6'b111110) begin errors++; $display("[TB] FAIL midrst_sel: got %b expected 111110", sel); end
    rst = 1'b0;
    dc = 0; bc = 0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) dc++;
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
    checks++; if (dc != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", dc); end
    checks++; if (bc != 0) begin errors++; $display("[TB] FAIL midrst_idle: got %0d busy cycles expected 0", bc); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [4];
    logic negs [4];
    logic [7*DIGITS:0] exp;
    int idx, lastDone;
    for (int i = 0; i < 4; i++) begin
      vals[i] = WIDTH'($urandom_range(0, 999999));
      negs[i] = 1'($urandom);
    end
    @(negedge clk);
    number = vals[0]; minusSign = negs[0]; load = 1'b1;
    idx = 0;
    lastDone = -1;
    for (int c = 0; c < 200 && idx < 4; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        exp = modelDisplay(longint'(vals[idx]), negs[idx]);
        checks++; if (seg !== exp[7*DIGITS-1:0]) begin errors++; $display("[TB] FAIL b2b_seg #%0d: got %b expected %b", idx, seg, exp[7*DIGITS-1:0]); end
        checks++; if (overflow !== exp[7*DIGITS]) begin errors++; $display("[TB] FAIL b2b_overflow #%0d: got %b expected %b", idx, overflow, exp[7*DIGITS]); end
        if (idx > 0) begin
          checks++; if (c - lastDone != 22) begin errors++; $display("[TB] FAIL b2b_interval #%0d: got %0d expected 22", idx, c - lastDone); end
        end
        lastDone = c;
        idx++;
        if (idx < 4) begin
          number = vals[idx]; minusSign = negs[idx];
        end else begin
          load = 1'b0;
        end
      end else begin
        number = WIDTH'($urandom);
        minusSign = 1'($urandom);
      end
    end
    load = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("[TB] FAIL b2b_completed: got %0d conversions expected 4", idx); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_scan();
    int bc, dc, fd, idx, len;
    logic [DIGITS-1:0] prevSel, cur, expSel;
    logic found;
    runConversion(20'd654321, 1'b0, bc, dc, fd);
    checks++; if (seg !== {numeral(6), numeral(5), numeral(4), numeral(3), numeral(2), numeral(1)}) begin errors++; $display("[TB] FAIL scan_value_seg: got %b expected 654321", seg); end
    prevSel = sel;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel !== prevSel) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL scan_step_seen: got no sel change expected one within 20 cycles"); end
    idx = -1;
    for (int i = 0; i < DIGITS; i++) begin
      expSel = ~(DIGITS'(1) << i);
      if (sel === expSel) idx = i;
    end
    checks++; if (idx < 0) begin errors++; $display("[TB] FAIL scan_onehot: got %b expected one low bit", sel); end
    if (idx < 0) idx = 0;
    for (int w = 0; w < 12; w++) begin
      expSel = ~(DIGITS'(1) << idx);
      checks++; if (sel !== expSel) begin errors++; $display("[TB] FAIL scan_sel step %0d: got %b expected %b", w, sel, expSel); end
      checks++; if (segScan !== numeral(idx + 1)) begin errors++; $display("[TB] FAIL scan_pattern step %0d: got %b expected %b", w, segScan, numeral(idx + 1)); end
      cur = sel;
      len = 0;
      while (sel === cur && len < 12) begin
        @(negedge clk);
        len++;
      end
      checks++; if (len != SCAN_DIV) begin errors++; $display("[TB] FAIL scan_hold step %0d: got %0d cycles expected %0d", w, len, SCAN_DIV); end
      idx = (idx + 1) % DIGITS;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_zero();
    test_minus_interior();
    test_overflow();
    test_random();
    test_load_ignored();
    test_reset_mid_conv();
    test_back_to_back();
    test_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_7_display_ctrl.md
# seg_7_display_ctrl

Parametrised seven-segment display controller for `DIGITS` digits, driven by a `WIDTH`-bit unsigned magnitude plus a sign flag.
- Converts the loaded value to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock, so there is no combinational divider chain.
- Applies leading-zero blanking, places a minus sign, and flags overflow when the value does not fit.
- Drives both a parallel all-digit segment bus and a time-multiplexed scan interface, for boards with static or shared-cathode displays.
- Sits between arithmetic/counter blocks and the board pins.

## Interface
- `DIGITS`, 6, number of display digits (2..8).
- `WIDTH`, 20, magnitude width in bits (4..32).
- `SCAN_DIV`, 50000, `sys_clk` cycles each digit stays selected in scan mode (≥2).
- `sys_clk` in 1: single clock; all logic is rising-edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `number` in `WIDTH`: magnitude to display.
- `minus_sign` in 1: value is negative.
- `load` in 1: start a conversion; sampled only when `busy`=0.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse when the segment outputs update.
- `overflow` out 1: the last loaded value did not fit.
- `seg` out `7*DIGITS`: parallel patterns; digit i is `seg[7*i+6:7*i]`, and digit 0 is the units digit.
- `sel` out `DIGITS`: one-hot, active-low digit select for scan mode.
- `seg_scan` out 7: pattern for the digit currently selected by `sel`.

## Operation

**Segment encoding.** Patterns are active-low, bit order {g,f,e,d,c,b,a}.
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- MINUS=0111111, BLANK=1111111

**State machine.**
- IDLE: `busy`=0. When `load`=1, capture `number` and `minus_sign`, clear the BCD register (4·`DIGITS` bits), set the sticky overflow flag to 0, load `WIDTH` into the bit counter, and go to CONV.
- CONV: `busy`=1. Each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, binary} left by 1. If the bit shifted out of the BCD MSB is 1, set sticky overflow. Decrement the counter; after the `WIDTH`th shift, go to FMT.
- FMT: `busy`=1. Update `seg` and `overflow`, pulse `done`, and return to IDLE.

**Formatting rules (FMT).**
- Value 0: digit 0 shows 0, all other digits BLANK, no minus even if `minus_sign`=1, `overflow`=0.
- Let m be the index of the most significant nonzero BCD nibble.
  - Digits 0..m show their numerals; interior zeros are shown.
  - Digits above m are BLANK.
  - If `minus_sign`=1, digit m+1 shows MINUS.
- Overflow when either:
  - sticky overflow is set (value ≥ 10^`DIGITS`), or
  - `minus_sign`=1 and m = `DIGITS`-1 (no room for the sign).
- On overflow, all digits show MINUS and `overflow`=1.

**Load and reset handling.**
- `load` is ignored while `busy`=1, and `number`/`minus_sign` are not re-sampled.
- `seg` holds its previous value until the next FMT.
- `sys_rst` asserted in any state, including mid-CONV, returns the block to IDLE and aborts the conversion. Reset values:
  - `busy`=0, `done`=0, `overflow`=0
  - `seg` all BLANK, `seg_scan`=BLANK
  - `sel`: only bit 0 low
  - scan counter 0, scan index 0

**Scan mode.** Scanning runs continuously and independently of the state machine.
- The scan counter counts 0..`SCAN_DIV`-1.
- At terminal count it wraps to 0 and the scan index advances; after `DIGITS`-1 the index wraps to 0.
- `sel` and `seg_scan` are registered together from the scan index and the current `seg`, so they always change on the same edge.

## Timing
- A `load` sampled at edge k moves to CONV at k, with `busy`=1 after k.
- Shifts occur on edges k+1..k+`WIDTH`.
- FMT runs at edge k+`WIDTH`+1: `seg`/`overflow` update, `done`=1 for that one cycle, `busy`=0.
- The next `load` is accepted at edge k+`WIDTH`+2. Load-to-display latency is `WIDTH`+1 cycles.
- If `load`=1 is held continuously, back-to-back conversions start every `WIDTH`+2 cycles.
- Each scan digit is held for exactly `SCAN_DIV` cycles. A `seg` change reaches `seg_scan` one cycle later, for the currently selected digit.
- `sys_rst` takes effect on the edge where it is sampled high.

## Test plan
Parameters: `DIGITS`=6, `WIDTH`=20 unless noted.
1. `number`=0, `minus_sign`=1 → after 21 cycles: digit 0=1000000, digits 1..5=BLANK, `overflow`=0, one `done` pulse.
2. `number`=1203, `minus_sign`=1 → digits 0..5 = 3, 0, 2, 1, MINUS, BLANK; `busy` high for exactly 21 cycles.
3. Overflow cases, each → all six digits MINUS, `overflow`=1:
   - `number`=1000000, `minus_sign`=0
   - `number`=100000, `minus_sign`=1
   
   Then `number`=999999, `minus_sign`=0 → all numerals 9, `overflow`=0.
4. `load` at 42, `load` again at cycle +5 with 77 → the second load is ignored and the display shows 42. Assert `sys_rst` mid-CONV → next cycle `busy`=0, `seg` all BLANK, and no `done` pulse.
5. `SCAN_DIV`=4, display 654321 → `sel` steps 111110→111101→…→011111→111110 every 4 cycles; each step's `seg_scan` matches that digit's pattern (1, 2, 3, 4, 5, 6).
